// File: rtl/pixel_dispatcher_pkg.sv
// Shared types for the ray-march front end: fixed-point vectors, FSM state
// encodings and default display geometry.
package pixel_dispatcher_pkg;

   localparam int DEF_DISPLAY_WIDTH  = 320;
   localparam int DEF_DISPLAY_HEIGHT = 240;
   localparam int DEF_H_BITS         = 9;
   localparam int DEF_V_BITS         = 8;

   typedef logic signed [15:0] fp_t;

   typedef struct packed {
      fp_t x;
      fp_t y;
      fp_t z;
   } vec3_t;

   typedef enum logic [1:0] {D_Idle, D_Dispatch, D_Drain} dispatcher_state_t;
   typedef enum logic [1:0] {R_Idle, R_March, R_Done} ray_unit_state_t;

   // Pointer width that stays legal for a single-unit build.
   function automatic int ptr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter (rr_arbiter): picks the first requester
// at or above ptr, wrapping modulo N.
module pixel_dispatcher_rr_arbiter
   import pixel_dispatcher_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]             req,
   input  logic [ptr_bits(N)-1:0]   ptr,
   output logic [N-1:0]             grant_onehot,
   output logic [ptr_bits(N)-1:0]   grant_idx,
   output logic                     any
);

   localparam int PW = ptr_bits(N);

   logic [PW-1:0] idx;

   // Walk downwards so the closest requester to ptr is written last and wins.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      idx          = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            grant_onehot      = '0;
            grant_onehot[idx] = 1'b1;
            grant_idx         = idx;
            any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel dispatcher feeding NUM_UNITS ray units with a per-frame
// camera snapshot. Define DISPATCHER_PERF_COUNT_EN to build the stall counter.
module pixel_dispatcher
   import pixel_dispatcher_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
   parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
   parameter int H_BITS         = DEF_H_BITS,
   parameter int V_BITS         = DEF_V_BITS,
   parameter int NUM_UNITS      = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 frame_start_in,
   input  vec3_t                cam_pos_in,
   input  vec3_t                cam_forward_in,
   input  logic [NUM_UNITS-1:0] unit_ready_in,
   output logic [NUM_UNITS-1:0] unit_valid_out,
   output logic [H_BITS-1:0]    hcount_out,
   output logic [V_BITS-1:0]    vcount_out,
   output vec3_t                ray_origin_out,
   output vec3_t                ray_direction_out,
   output logic                 busy_out,
   output logic                 frame_done_out,
   output logic [15:0]          frame_count_out,
   output logic [31:0]          stall_cycles_out
);

   localparam int PW = ptr_bits(NUM_UNITS);

   dispatcher_state_t    state;
   logic [PW-1:0]        rr_ptr;
   logic [H_BITS-1:0]    hcount;
   logic [V_BITS-1:0]    vcount;
   vec3_t                origin;
   vec3_t                direction;
   logic                 frame_done;
   logic [15:0]          frame_count;

   logic [NUM_UNITS-1:0] grant_onehot;
   logic [PW-1:0]        grant_idx;
   logic                 grant_any;
   logic                 xfer;
   logic                 line_end;
   logic                 last_pix;

   pixel_dispatcher_rr_arbiter #(.N(NUM_UNITS)) u_arb (
      .req          (unit_ready_in),
      .ptr          (rr_ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   // The grant is a subset of ready, so any grant in D_Dispatch is a transfer.
   assign xfer     = (state == D_Dispatch) && grant_any;
   assign line_end = (hcount == H_BITS'(DISPLAY_WIDTH - 1));
   assign last_pix = line_end && (vcount == V_BITS'(DISPLAY_HEIGHT - 1));

   assign unit_valid_out    = (state == D_Dispatch) ? grant_onehot : '0;
   assign hcount_out        = hcount;
   assign vcount_out        = vcount;
   assign ray_origin_out    = origin;
   assign ray_direction_out = direction;
   assign busy_out          = (state != D_Idle);
   assign frame_done_out    = frame_done;
   assign frame_count_out   = frame_count;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= D_Idle;
         rr_ptr      <= '0;
         hcount      <= '0;
         vcount      <= '0;
         origin      <= '0;
         direction   <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            D_Idle: begin
               if (frame_start_in) begin
                  origin    <= cam_pos_in;
                  direction <= cam_forward_in;
                  hcount    <= '0;
                  vcount    <= '0;
                  state     <= D_Dispatch;
               end
            end
            D_Dispatch: begin
               if (xfer) begin
                  rr_ptr <= (grant_idx == PW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
                  if (last_pix) begin
                     state <= D_Drain;
                  end else if (line_end) begin
                     hcount <= '0;
                     vcount <= vcount + 1'b1;
                  end else begin
                     hcount <= hcount + 1'b1;
                  end
               end
            end
            D_Drain: begin
               // Entered on the last transfer's edge, so that unit's ready has already dropped here.
               if (&unit_ready_in) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  state       <= D_Idle;
               end
            end
            default: state <= D_Idle;
         endcase
      end
   end

`ifdef DISPATCHER_PERF_COUNT_EN
   logic [31:0] stall_cycles;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stall_cycles <= '0;
      end else if (state == D_Idle && frame_start_in) begin
         stall_cycles <= '0;
      end else if (state == D_Dispatch && unit_ready_in == '0 && stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

   assign stall_cycles_out = stall_cycles;
`else
   assign stall_cycles_out = '0;
`endif

endmodule
